// File: rtl/hpdcache_perf_cnt_bank.sv
// HPDcache performance-event counter bank with freeze/clear/snapshot and a registered indexed read port.
// Build option: define HPDCACHE_PERF_CNT_SATURATE_EN to saturate counters instead of wrapping.
//
// Response register states:
//   state      | meaning
//   RSP_EMPTY  | no response held, request side always ready
//   RSP_FULL   | response held on rd_rsp_*_o until rd_rsp_ready_i

module hpdcache_perf_cnt_bank #(
    parameter int CNT_WIDTH = 32,
    parameter int NB_EVT    = 11
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NB_EVT-1:0]    evt_i,
    input  logic                 freeze_i,
    input  logic                 clr_i,
    input  logic                 snap_i,
    input  logic                 rd_valid_i,
    output logic                 rd_ready_o,
    input  logic [3:0]           rd_idx_i,
    input  logic                 rd_snap_i,
    output logic                 rd_rsp_valid_o,
    input  logic                 rd_rsp_ready_i,
    output logic [CNT_WIDTH-1:0] rd_rsp_data_o,
    output logic                 rd_rsp_err_o,
    output logic [NB_EVT-1:0]    ovf_o
);

    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_e;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [4:0]           NB_EVT_L = 5'(NB_EVT);

    logic [CNT_WIDTH-1:0] live_q [NB_EVT];
    logic [CNT_WIDTH-1:0] live_d [NB_EVT];
    logic [CNT_WIDTH-1:0] snap_q [NB_EVT];
    logic [CNT_WIDTH-1:0] snap_d [NB_EVT];
    logic [NB_EVT-1:0]    ovf_q;
    logic [NB_EVT-1:0]    ovf_d;

    rsp_state_e           state_q;
    rsp_state_e           state_d;
    logic [CNT_WIDTH-1:0] rsp_data_q;
    logic [CNT_WIDTH-1:0] rsp_data_d;
    logic                 rsp_err_q;
    logic                 rsp_err_d;

    logic                 rd_accept;
    logic                 rd_idx_ok;
    logic [CNT_WIDTH-1:0] rd_sel_data;

    // Live counters: clear beats freeze beats increment.
    always_comb begin
        for (int i = 0; i < NB_EVT; i++) begin
            live_d[i] = live_q[i];
            ovf_d[i]  = ovf_q[i];
            if (clr_i) begin
                live_d[i] = '0;
                ovf_d[i]  = 1'b0;
            end else if (!freeze_i && evt_i[i]) begin
                if (live_q[i] == CNT_MAX) begin
                    ovf_d[i] = 1'b1;
`ifdef HPDCACHE_PERF_CNT_SATURATE_EN
                    live_d[i] = live_q[i];
`else
                    live_d[i] = '0;
`endif
                end else begin
                    live_d[i] = live_q[i] + 1'b1;
                end
            end
        end
    end

    // Snapshot takes the registered (pre-clear, pre-increment) live values.
    always_comb begin
        for (int i = 0; i < NB_EVT; i++) begin
            snap_d[i] = snap_q[i];
            if (snap_i) begin
                snap_d[i] = live_q[i];
            end
        end
    end

    always_comb begin
        rd_idx_ok   = ({1'b0, rd_idx_i} < NB_EVT_L);
        rd_sel_data = '0;
        for (int i = 0; i < NB_EVT; i++) begin
            if (rd_idx_i == 4'(i)) begin
                rd_sel_data = rd_snap_i ? snap_q[i] : live_q[i];
            end
        end
    end

    assign rd_ready_o = (state_q == RSP_EMPTY) || rd_rsp_ready_i;
    assign rd_accept  = rd_valid_i && rd_ready_o;

    always_comb begin
        state_d    = state_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            RSP_EMPTY: begin
                if (rd_accept) begin
                    state_d = RSP_FULL;
                end
            end
            RSP_FULL: begin
                if (rd_rsp_ready_i && !rd_accept) begin
                    state_d = RSP_EMPTY;
                end
            end
            default: state_d = RSP_EMPTY;
        endcase
        if (rd_accept) begin
            rsp_data_d = rd_idx_ok ? rd_sel_data : '0;
            rsp_err_d  = !rd_idx_ok;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NB_EVT; i++) begin
                live_q[i] <= '0;
                snap_q[i] <= '0;
            end
            ovf_q      <= '0;
            state_q    <= RSP_EMPTY;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NB_EVT; i++) begin
                live_q[i] <= live_d[i];
                snap_q[i] <= snap_d[i];
            end
            ovf_q      <= ovf_d;
            state_q    <= state_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign rd_rsp_valid_o = (state_q == RSP_FULL);
    assign rd_rsp_data_o  = rsp_data_q;
    assign rd_rsp_err_o   = rsp_err_q;
    assign ovf_o          = ovf_q;

endmodule

// File: tb/tb_hpdcache_perf_cnt_bank.sv
// Bench for hpdcache_perf_cnt_bank (8-bit counters so overflow is reachable); honours HPDCACHE_PERF_CNT_SATURATE_EN.

module tb_hpdcache_perf_cnt_bank;

    localparam int W    = 8;
    localparam int N    = 11;
    localparam int MAXV = (1 << W) - 1;
`ifdef HPDCACHE_PERF_CNT_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] evt;
    logic         freeze, clr, snap;
    logic         rd_valid, rd_snap, rsp_ready;
    logic [3:0]   rd_idx;
    logic         rd_ready_o, rd_rsp_valid_o, rd_rsp_err_o;
    logic [W-1:0] rd_rsp_data_o;
    logic [N-1:0] ovf_o;

    int vectors = 0;
    int miscompares = 0;

    // reference model
    int           live_m [N];
    int           snap_m [N];
    logic [N-1:0] ovf_m;
    bit           v_m;
    int           d_m;
    bit           e_m;

    hpdcache_perf_cnt_bank #(.CNT_WIDTH(W), .NB_EVT(N)) dut (
        .clk_i(clk), .rst_i(rst), .evt_i(evt), .freeze_i(freeze), .clr_i(clr), .snap_i(snap),
        .rd_valid_i(rd_valid), .rd_ready_o(rd_ready_o), .rd_idx_i(rd_idx), .rd_snap_i(rd_snap),
        .rd_rsp_valid_o(rd_rsp_valid_o), .rd_rsp_ready_i(rsp_ready),
        .rd_rsp_data_o(rd_rsp_data_o), .rd_rsp_err_o(rd_rsp_err_o), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    // One clock: advance the model with the current inputs, then step past the edge.
    task automatic tick();
        bit acc;
        #1;
        acc = rd_valid && (!v_m || rsp_ready);
        if (rst) begin
            for (int i = 0; i < N; i++) begin live_m[i] = 0; snap_m[i] = 0; end
            ovf_m = '0; v_m = 0; d_m = 0; e_m = 0;
        end else begin
            if (acc) begin
                v_m = 1;
                if (rd_idx < N) begin d_m = rd_snap ? snap_m[rd_idx] : live_m[rd_idx]; e_m = 0; end
                else begin d_m = 0; e_m = 1; end
            end else if (rsp_ready) begin
                v_m = 0;
            end
            if (snap) for (int i = 0; i < N; i++) snap_m[i] = live_m[i];
            for (int i = 0; i < N; i++) begin
                if (clr) begin
                    live_m[i] = 0; ovf_m[i] = 1'b0;
                end else if (!freeze && evt[i]) begin
                    if (live_m[i] + 1 > MAXV) begin
                        ovf_m[i] = 1'b1;
                        live_m[i] = SAT ? MAXV : 0;
                    end else begin
                        live_m[i] = live_m[i] + 1;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; evt = '0; freeze = 0; clr = 0; snap = 0;
        rd_valid = 0; rd_idx = '0; rd_snap = 0; rsp_ready = 1;
    endtask

    task automatic do_clear();
        idle(); clr = 1; tick(); clr = 0; tick();
    endtask

    task automatic pulse(input int idx, input int n);
        for (int k = 0; k < n; k++) begin
            evt = '0; evt[idx] = 1'b1; tick();
        end
        evt = '0;
    endtask

    task automatic issue_read(input int idx, input bit from_snap);
        rd_valid = 1; rd_idx = 4'(idx); rd_snap = from_snap; rsp_ready = 1;
        tick();
        rd_valid = 0;
    endtask

    task automatic test_reset();
        idle(); rst = 1; tick(); tick(); rst = 0;
        vectors++;
        if (rd_rsp_valid_o !== 1'b0 || rd_rsp_data_o !== '0 || rd_rsp_err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_rsp got valid=%0b data=%0d err=%0b want 0/0/0", rd_rsp_valid_o, rd_rsp_data_o, rd_rsp_err_o);
        end
        vectors++;
        if (ovf_o !== '0 || rd_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_flags got ovf=%b ready=%0b want 0/1", ovf_o, rd_ready_o);
        end
    endtask

    task automatic test_count_read();
        do_clear();
        pulse(5, 7);
        vectors++;
        if (rd_rsp_valid_o !== 1'b0) begin
            miscompares++; $display("FAIL count_pre_valid got %0b want 0", rd_rsp_valid_o);
        end
        issue_read(5, 0);
        vectors++;
        if (rd_rsp_valid_o !== 1'b1 || rd_rsp_data_o !== W'(7) || rd_rsp_err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL count_read5 got valid=%0b data=%0d err=%0b want 1/7/0", rd_rsp_valid_o, rd_rsp_data_o, rd_rsp_err_o);
        end
        tick();
        vectors++;
        if (rd_rsp_valid_o !== 1'b0) begin
            miscompares++; $display("FAIL count_drain got valid=%0b want 0", rd_rsp_valid_o);
        end
    endtask

    task automatic test_freeze();
        do_clear();
        freeze = 1;
        for (int k = 0; k < 4; k++) begin pulse(0, 1); tick(); end
        freeze = 0;
        for (int k = 0; k < 2; k++) begin pulse(0, 1); tick(); end
        issue_read(0, 0);
        vectors++;
        if (rd_rsp_valid_o !== 1'b1 || rd_rsp_data_o !== W'(2)) begin
            miscompares++; $display("FAIL freeze_read0 got valid=%0b data=%0d want 1/2", rd_rsp_valid_o, rd_rsp_data_o);
        end
        tick();
    endtask

    task automatic test_snap_clr();
        do_clear();
        pulse(6, 10);
        snap = 1; clr = 1; tick(); snap = 0; clr = 0;
        pulse(6, 3);
        issue_read(6, 1);
        vectors++;
        if (rd_rsp_data_o !== W'(10) || rd_rsp_err_o !== 1'b0) begin
            miscompares++; $display("FAIL snap_read6 got data=%0d err=%0b want 10/0", rd_rsp_data_o, rd_rsp_err_o);
        end
        issue_read(6, 0);
        vectors++;
        if (rd_rsp_data_o !== W'(3)) begin
            miscompares++; $display("FAIL live_read6 got data=%0d want 3", rd_rsp_data_o);
        end
        tick();
    endtask

    task automatic test_overflow();
        int exp_v;
        logic [N-1:0] exp_ovf;
        do_clear();
        evt = '0; evt[2] = 1'b1;
        for (int k = 0; k < 257; k++) tick();
        evt = '0;
        exp_v = SAT ? 255 : 1;
        exp_ovf = '0; exp_ovf[2] = 1'b1;
        issue_read(2, 0);
        vectors++;
        if (rd_rsp_data_o !== W'(exp_v)) begin
            miscompares++; $display("FAIL ovf_read2 got data=%0d want %0d", rd_rsp_data_o, exp_v);
        end
        vectors++;
        if (ovf_o !== exp_ovf) begin
            miscompares++; $display("FAIL ovf_flags got %b want %b", ovf_o, exp_ovf);
        end
        tick();
    endtask

    task automatic test_err_and_stall();
        logic [W-1:0] held;
        issue_read(12, 0);
        vectors++;
        if (rd_rsp_valid_o !== 1'b1 || rd_rsp_data_o !== '0 || rd_rsp_err_o !== 1'b1) begin
            miscompares++;
            $display("FAIL err_read12 got valid=%0b data=%0d err=%0b want 1/0/1", rd_rsp_valid_o, rd_rsp_data_o, rd_rsp_err_o);
        end
        tick();
        rd_valid = 1; rd_idx = 4'd6; rd_snap = 1; rsp_ready = 0;
        tick();
        held = rd_rsp_data_o;
        vectors++;
        if (held !== W'(d_m) || rd_rsp_valid_o !== 1'b1) begin
            miscompares++; $display("FAIL stall_first got data=%0d valid=%0b want %0d/1", held, rd_rsp_valid_o, d_m);
        end
        rd_idx = 4'd2; rd_snap = 0;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (rd_ready_o !== 1'b0 || rd_rsp_valid_o !== 1'b1 || rd_rsp_data_o !== held || rd_rsp_err_o !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_hold cyc=%0d got ready=%0b valid=%0b data=%0d want 0/1/%0d", k, rd_ready_o, rd_rsp_valid_o, rd_rsp_data_o, held);
            end
            tick();
        end
        rsp_ready = 1; #1;
        vectors++;
        if (rd_ready_o !== 1'b1) begin
            miscompares++; $display("FAIL stall_release got ready=%0b want 1", rd_ready_o);
        end
        tick();
        rd_valid = 0;
        vectors++;
        if (rd_rsp_valid_o !== 1'b1 || rd_rsp_data_o !== W'(d_m) || d_m != (SAT ? 255 : 1)) begin
            miscompares++; $display("FAIL b2b_read2 got data=%0d model=%0d valid=%0b", rd_rsp_data_o, d_m, rd_rsp_valid_o);
        end
        tick();
    endtask

    task automatic test_reset_mid_read();
        pulse(4, 5);
        rd_valid = 1; rd_idx = 4'd4; rd_snap = 0; rsp_ready = 0;
        tick();
        rd_valid = 0; rst = 1;
        tick();
        rst = 0; rsp_ready = 1;
        vectors++;
        if (rd_rsp_valid_o !== 1'b0 || ovf_o !== '0) begin
            miscompares++; $display("FAIL rst_mid_valid got valid=%0b ovf=%b want 0/0", rd_rsp_valid_o, ovf_o);
        end
        tick();
        vectors++;
        if (rd_rsp_valid_o !== 1'b0) begin
            miscompares++; $display("FAIL rst_no_rsp got valid=%0b want 0", rd_rsp_valid_o);
        end
        for (int i = 0; i < N; i++) begin
            issue_read(i, i[0]);
            vectors++;
            if (rd_rsp_valid_o !== 1'b1 || rd_rsp_data_o !== '0) begin
                miscompares++; $display("FAIL rst_cnt idx=%0d got valid=%0b data=%0d want 1/0", i, rd_rsp_valid_o, rd_rsp_data_o);
            end
        end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 2000; c++) begin
            evt      = N'($urandom);
            freeze   = ($urandom_range(0, 3) == 0);
            clr      = ($urandom_range(0, 299) == 0);
            snap     = ($urandom_range(0, 15) == 0);
            rd_valid = $urandom_range(0, 1);
            rd_idx   = 4'($urandom_range(0, 12));
            rd_snap  = $urandom_range(0, 1);
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            vectors++;
            if (rd_ready_o !== (!v_m || rsp_ready)) begin
                miscompares++; $display("FAIL rnd_ready cyc=%0d got %0b want %0b", c, rd_ready_o, !v_m || rsp_ready);
            end
            tick();
            vectors++;
            if (rd_rsp_valid_o !== v_m || ovf_o !== ovf_m ||
                (v_m && (rd_rsp_data_o !== W'(d_m) || rd_rsp_err_o !== e_m))) begin
                miscompares++;
                $display("FAIL rnd_rsp cyc=%0d got v=%0b d=%0d e=%0b ovf=%b want v=%0b d=%0d e=%0b ovf=%b",
                         c, rd_rsp_valid_o, rd_rsp_data_o, rd_rsp_err_o, ovf_o, v_m, d_m, e_m, ovf_m);
            end
        end
        idle();
        for (int i = 0; i < N; i++) begin
            issue_read(i, 0);
            vectors++;
            if (rd_rsp_data_o !== W'(live_m[i])) begin
                miscompares++; $display("FAIL rnd_final idx=%0d got %0d want %0d", i, rd_rsp_data_o, live_m[i]);
            end
        end
        tick();
    endtask

    initial begin
        idle();
        for (int i = 0; i < N; i++) begin live_m[i] = 0; snap_m[i] = 0; end
        ovf_m = '0; v_m = 0; d_m = 0; e_m = 0;
        test_reset();
        test_count_read();
        test_freeze();
        test_snap_clr();
        test_overflow();
        test_err_and_stall();
        test_reset_mid_read();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
